alu_seq_hs: RTL and testbench

//   Parametrised, registered ALU with valid/ready handshake on input and output.

---
 rtl/alu_seq_hs.sv | 190 +++++++++++++++++++
 tb/tb_alu_seq_hs.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_hs.sv
// Registered ALU with valid/ready handshake on input and output, N/Z/C/V flags and
// illegal-opcode reporting. Define ALU_SEQ_MUL_EN to add the iterative shift-add MUL (1000).
module alu_seq_hs #(
   parameter int unsigned WIDTH   = 64,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             ResetL,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] BusA,
   input  logic [WIDTH-1:0] BusB,
   input  logic [3:0]       ALUCtrl,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] BusW,
   output logic             Zero,
   output logic             Negative,
   output logic             Carry,
   output logic             Overflow,
   output logic             IllegalOp
);

   localparam logic [3:0] OpAnd  = 4'b0000;
   localparam logic [3:0] OpOr   = 4'b0001;
   localparam logic [3:0] OpAdd  = 4'b0010;
   localparam logic [3:0] OpLsl  = 4'b0011;
   localparam logic [3:0] OpLsr  = 4'b0100;
   localparam logic [3:0] OpSub  = 4'b0110;
   localparam logic [3:0] OpPass = 4'b0111;
   localparam logic [3:0] OpMul  = 4'b1000;

   typedef enum logic [1:0] {StIdle, StBusy, StHold} state_e;

   state_e             state_q, state_d;
   logic               ready_q;
   logic [WIDTH-1:0]   w_q, w_d;
   logic               z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, ill_q, ill_d;

   logic               accept, is_mul, is_sub, mul_done;
   logic [WIDTH-1:0]   mul_res, b_eff, alu_w;
   logic               alu_c, alu_v, alu_ill;
   logic [WIDTH:0]     sum_ext;
   logic [SHAMT_W-1:0] shamt;

   // ready_q keeps InReady low until the first clock after reset release
   assign InReady  = ready_q & ((state_q == StIdle) | ((state_q == StHold) & OutReady));
   assign OutValid = (state_q == StHold);
   assign accept   = InValid & InReady;

   assign shamt   = BusB[SHAMT_W-1:0];
   assign is_sub  = (ALUCtrl == OpSub);
   // SUB as A + ~B + 1 so bit WIDTH is the no-borrow carry
   assign b_eff   = is_sub ? ~BusB : BusB;
   assign sum_ext = {1'b0, BusA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

   always_comb begin
      alu_w   = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_ill = 1'b0;
      case (ALUCtrl)
         OpAnd:  alu_w = BusA & BusB;
         OpOr:   alu_w = BusA | BusB;
         OpPass: alu_w = BusB;
         OpLsl:  alu_w = BusA << shamt;
         OpLsr:  alu_w = BusA >> shamt;
         OpAdd, OpSub: begin
            alu_w = sum_ext[WIDTH-1:0];
            alu_c = sum_ext[WIDTH];
            alu_v = (BusA[WIDTH-1] == b_eff[WIDTH-1]) & (sum_ext[WIDTH-1] != BusA[WIDTH-1]);
         end
         default: alu_ill = 1'b1;
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   logic [WIDTH-1:0]   mcand_q, mplier_q, acc_q;
   logic [SHAMT_W-1:0] cnt_q;
   logic               done_q;

   assign is_mul   = (ALUCtrl == OpMul);
   assign mul_done = done_q;
   assign mul_res  = acc_q;

   // One shift-add step per BUSY cycle; done_q adds the final result-transfer cycle
   always_ff @(posedge CLK or negedge ResetL) begin
      if (!ResetL) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
      end else if (accept && is_mul) begin
         mcand_q  <= BusA;
         mplier_q <= BusB;
         acc_q    <= '0;
         cnt_q    <= SHAMT_W'(WIDTH - 1);
         done_q   <= 1'b0;
      end else if ((state_q == StBusy) && !done_q) begin
         if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
         end
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         if (cnt_q == '0) begin
            done_q <= 1'b1;
         end else begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end
`else
   assign is_mul   = 1'b0;
   assign mul_done = 1'b0;
   assign mul_res  = '0;
`endif

   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      z_d     = z_q;
      n_d     = n_q;
      c_d     = c_q;
      v_d     = v_q;
      ill_d   = ill_q;
      unique case (state_q)
         StIdle, StHold: begin
            if ((state_q == StHold) && OutReady && !InValid) begin
               state_d = StIdle;
            end
            if (accept) begin
               if (is_mul) begin
                  state_d = StBusy;
               end else begin
                  state_d = StHold;
                  w_d     = alu_w;
                  z_d     = (alu_w == '0);
                  n_d     = alu_w[WIDTH-1];
                  c_d     = alu_c;
                  v_d     = alu_v;
                  ill_d   = alu_ill;
               end
            end
         end
         StBusy: begin
            if (mul_done) begin
               state_d = StHold;
               w_d     = mul_res;
               z_d     = (mul_res == '0);
               n_d     = mul_res[WIDTH-1];
               c_d     = 1'b0;
               v_d     = 1'b0;
               ill_d   = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge ResetL) begin
      if (!ResetL) begin
         state_q <= StIdle;
         ready_q <= 1'b0;
         w_q     <= '0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= 1'b1;
         w_q     <= w_d;
         z_q     <= z_d;
         n_q     <= n_d;
         c_q     <= c_d;
         v_q     <= v_d;
         ill_q   <= ill_d;
      end
   end

   assign BusW      = w_q;
   assign Zero      = z_q;
   assign Negative  = n_q;
   assign Carry     = c_q;
   assign Overflow  = v_q;
   assign IllegalOp = ill_q;

endmodule

// File: tb/tb_alu_seq_hs.sv
// Scoreboard bench for alu_seq_hs: the driver pushes model results, a negedge monitor pops them.
// Expectations follow ALU_SEQ_MUL_EN when it is defined for the build.
module tb_alu_seq_hs;

   localparam int W = 64;

   typedef struct packed {
      logic [W-1:0] w;
      logic         z, n, c, v, ill;
   } res_t;

   logic         CLK = 1'b0;
   logic         ResetL = 1'b0;
   logic         InValid = 1'b0;
   logic         InReady;
   logic [W-1:0] BusA = '0;
   logic [W-1:0] BusB = '0;
   logic [3:0]   ALUCtrl = 4'h0;
   logic         OutValid;
   logic         OutReady = 1'b0;
   logic [W-1:0] BusW;
   logic         Zero, Negative, Carry, Overflow, IllegalOp;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   rdy_mode = 0;   // 0: OutReady=1, 1: random, 2: OutReady=0
   int   acc_cyc = 0;
   res_t exp_q[$];

   alu_seq_hs #(.WIDTH(W)) dut (
      .CLK(CLK), .ResetL(ResetL), .InValid(InValid), .InReady(InReady),
      .BusA(BusA), .BusB(BusB), .ALUCtrl(ALUCtrl), .OutValid(OutValid),
      .OutReady(OutReady), .BusW(BusW), .Zero(Zero), .Negative(Negative),
      .Carry(Carry), .Overflow(Overflow), .IllegalOp(IllegalOp)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   function automatic res_t mk(input logic [W-1:0] w, input logic z, n, c, v, ill);
      res_t r;
      r.w = w; r.z = z; r.n = n; r.c = c; r.v = v; r.ill = ill;
      return r;
   endfunction

   // Reference: signed results held at W+1 bits; overflow when the W-bit result misrepresents them
   function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, b);
      res_t r;
      logic signed [W:0] sa, sb, exact;
      logic [W:0] wide;
      r = '0;
      sa = $signed({a[W-1], a});
      sb = $signed({b[W-1], b});
      case (op)
         4'b0000: r.w = a & b;
         4'b0001: r.w = a | b;
         4'b0111: r.w = b;
         4'b0011: r.w = a << (b % W);
         4'b0100: r.w = a >> (b % W);
         4'b0010: begin
            wide  = {1'b0, a} + {1'b0, b};
            r.w   = wide[W-1:0];
            r.c   = wide[W];
            exact = sa + sb;
            r.v   = (exact != $signed({r.w[W-1], r.w}));
         end
         4'b0110: begin
            r.w   = a - b;
            r.c   = (a >= b);
            exact = sa - sb;
            r.v   = (exact != $signed({r.w[W-1], r.w}));
         end
`ifdef ALU_SEQ_MUL_EN
         4'b1000: r.w = a * b;
`endif
         default: r.ill = 1'b1;
      endcase
      r.z = (r.w == '0);
      r.n = r.w[W-1];
      return r;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      case (rdy_mode)
         0:       OutReady = 1'b1;
         1:       OutReady = ($urandom_range(0, 3) != 0);
         default: OutReady = 1'b0;
      endcase
   endtask

   // Call at posedge+1; returns at posedge+1 after the accepting edge
   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, b, input res_t e);
      int n = 0;
      InValid = 1'b1; ALUCtrl = op; BusA = a; BusB = b;
      forever begin
         @(negedge CLK);
         if (InReady) break;
         n++;
         if (n > 300) begin
            chk("accept_timeout", 64'(n), 64'd0);
            break;
         end
         tick();
      end
      if (n <= 300) begin
         exp_q.push_back(e);
         acc_cyc = cyc;
      end
      tick();
      InValid = 1'b0;
      BusA = {$urandom, $urandom}; BusB = {$urandom, $urandom};
      ALUCtrl = 4'($urandom_range(0, 15));
   endtask

   // Call straight after issue(); counts edges from accept to OutValid
   task automatic check_latency(input int exp_n, input string name);
      int n = 1;
      logic busy_rdy = 1'b0;
      forever begin
         @(negedge CLK);
         if (OutValid) break;
         if (InReady !== 1'b0) busy_rdy = 1'b1;
         if (n > 300) break;
         tick();
         n++;
      end
      chk(name, 64'(n), 64'(exp_n));
      chk({name, "_inready_busy"}, {63'd0, busy_rdy}, 64'd0);
      tick();
   endtask

   // Monitor: scoreboard pop on output transfer, plus hold-stability checks
   initial begin
      res_t act, e, snap;
      logic hold_v = 1'b0;
      forever begin
         @(negedge CLK);
         act = mk(BusW, Zero, Negative, Carry, Overflow, IllegalOp);
         if (!ResetL) begin
            hold_v = 1'b0;
            continue;
         end
         if (hold_v && OutValid) begin
            checks++;
            if (act !== snap) begin
               errors++;
               $display("FAIL hold_stable: got %h, required %h", act, snap);
            end
         end
         if (OutValid && !OutReady) chk("inready_in_hold", {63'd0, InReady}, 64'd0);
         hold_v = OutValid && !OutReady;
         snap = act;
         if (OutValid && OutReady) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_out: got w=%h, required no output", BusW);
            end else begin
               e = exp_q.pop_front();
               if (act !== e) begin
                  errors++;
                  $display("FAIL result: got w=%h z%0b n%0b c%0b v%0b ill%0b, required w=%h z%0b n%0b c%0b v%0b ill%0b",
                           act.w, act.z, act.n, act.c, act.v, act.ill,
                           e.w, e.z, e.n, e.c, e.v, e.ill);
               end
            end
         end
      end
   end

   initial begin
      logic [3:0] legal [8];
      logic [3:0] op;
      logic [W-1:0] a, b;
      int c0;
      legal[0] = 4'b0000; legal[1] = 4'b0001; legal[2] = 4'b0010; legal[3] = 4'b0110;
      legal[4] = 4'b0111; legal[5] = 4'b0011; legal[6] = 4'b0100; legal[7] = 4'b1000;

      // Reset state
      #2;
      chk("rst_outvalid", {63'd0, OutValid}, 64'd0);
      chk("rst_busw", BusW, 64'd0);
      chk("rst_flags", {59'd0, Zero, Negative, Carry, Overflow, IllegalOp}, 64'd0);
      chk("rst_inready", {63'd0, InReady}, 64'd0);
      repeat (2) @(posedge CLK);
      #1 ResetL = 1'b1;
      @(negedge CLK);
      chk("inready_before_clk", {63'd0, InReady}, 64'd0);
      @(negedge CLK);
      chk("inready_after_clk", {63'd0, InReady}, 64'd1);
      rdy_mode = 0;
      tick();

      // 1: ADD wrap to zero
      issue(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, mk(64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
      check_latency(1, "add_latency");
      // 2: SUB signed overflow
      issue(4'b0110, 64'h8000_0000_0000_0000, 64'd1,
            mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
      check_latency(1, "sub_latency");

      // 3: back-to-back, then hold OutReady low for 3 cycles
      issue(4'b0000, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_1111,
            model(4'b0000, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_1111));
      c0 = acc_cyc;
      issue(4'b0001, 64'hF0F0_0000_0000_0001, 64'h0000_0000_0000_0000,
            model(4'b0001, 64'hF0F0_0000_0000_0001, 64'h0));
      issue(4'b0011, 64'd1, 64'd63, mk(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      issue(4'b0100, 64'h8000_0000_0000_0000, 64'h43,
            mk(64'h1000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      chk("b2b_accepts", 64'(acc_cyc - c0), 64'd3);
      rdy_mode = 2;
      OutReady = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         chk("hold_outvalid", {63'd0, OutValid}, 64'd1);
         tick();
      end
      rdy_mode = 0;
      OutReady = 1'b1;
      tick();

      // 4: MUL
`ifdef ALU_SEQ_MUL_EN
      issue(4'b1000, 64'h1_0000_0001, 64'd3, mk(64'h3_0000_0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      check_latency(W + 1, "mul_latency");
`else
      issue(4'b1000, 64'h1_0000_0001, 64'd3, mk(64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      check_latency(1, "mul_illegal_latency");
`endif

      // 5: illegal opcode then PassB
      issue(4'b1111, 64'hDEAD, 64'hBEEF, mk(64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      issue(4'b0111, 64'hDEAD, 64'd5, mk(64'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      repeat (3) tick();

      // 6: reset during MUL
      issue(4'b1000, 64'h1234_5678, 64'h9ABC_DEF0, model(4'b1000, 64'h1234_5678, 64'h9ABC_DEF0));
      repeat (19) tick();
      ResetL = 1'b0;
      #1;
      chk("midrst_outvalid", {63'd0, OutValid}, 64'd0);
      chk("midrst_busw", BusW, 64'd0);
      chk("midrst_inready", {63'd0, InReady}, 64'd0);
      exp_q.delete();
      tick();
      ResetL = 1'b1;
      tick();
      @(negedge CLK);
      chk("postrst_inready", {63'd0, InReady}, 64'd1);
      tick();
      issue(4'b0010, 64'd2, 64'd3, mk(64'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      check_latency(1, "postrst_latency");

      // Randomized traffic with random back-pressure
      rdy_mode = 1;
      for (int i = 0; i < 250; i++) begin
         op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                          : legal[$urandom_range(0, 7)];
         case ($urandom_range(0, 5))
            0:       a = 64'hFFFF_FFFF_FFFF_FFFF;
            1:       a = 64'h8000_0000_0000_0000;
            2:       a = 64'h7FFF_FFFF_FFFF_FFFF;
            default: a = {$urandom, $urandom};
         endcase
         case ($urandom_range(0, 5))
            0:       b = a;
            1:       b = 64'h8000_0000_0000_0000;
            2:       b = 64'($urandom_range(0, 255));
            default: b = {$urandom, $urandom};
         endcase
         issue(op, a, b, model(op, a, b));
         repeat ($urandom_range(0, 2)) tick();
      end

      rdy_mode = 0;
      OutReady = 1'b1;
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
